rw_mem_arbiter: RTL



---
 rtl/rw_mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rw_mem_arbiter.sv
// rw_mem_arbiter: two-requester round-robin arbiter and sequencer for the
// 96x8 synchronous RAM mapped at BASE_ADDR..TOP_ADDR (128..223).
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN   requester N (N = 0,1) request, held until ackN/errN
//   lockN                   requester N lock request (RW_ARB_LOCK_EN only)
//   ackN, errN              one-cycle completion / out-of-range pulses
//   rdata                   read data, valid in the ackN cycle
//   mem_address/mem_WE/mem_data_in   RAM control, owned by this block
//   mem_data_out            RAM registered read data
// Optional feature: define RW_ARB_LOCK_EN to add lock0/lock1 exclusive-access
// ports; without it the arbiter is pure round-robin.
module rw_mem_arbiter #(
  parameter int unsigned BASE_ADDR = 128,
  parameter int unsigned TOP_ADDR  = 223
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
`ifdef RW_ARB_LOCK_EN
  input  logic       lock0,
  input  logic       lock1,
`endif
  output logic       ack0,
  output logic       ack1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] rdata,
  output logic [7:0] mem_address,
  output logic       mem_WE,
  output logic [7:0] mem_data_in,
  input  logic [7:0] mem_data_out
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] BASE_A = AW'(BASE_ADDR);
  localparam logic [AW-1:0] TOP_A  = AW'(TOP_ADDR);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t        state;
  logic          last_grant;
  logic          cur;
  logic          cur_we;
  logic          elig0;
  logic          elig1;
  logic          win1;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_inr;
`ifdef RW_ARB_LOCK_EN
  logic          lock_act;
  logic          lock_own;
  logic          cur_lock;
  logic          w_lock;
`endif

  // Eligibility and winner selection; a requester in its own ack cycle is
  // excluded so a still-held req is not granted twice.
  always_comb begin
    elig0 = req0 && !ack0 && !err0;
    elig1 = req1 && !ack1 && !err1;
`ifdef RW_ARB_LOCK_EN
    if (lock_act) begin
      if (lock_own) elig0 = 1'b0;
      else          elig1 = 1'b0;
    end
`endif
    win1    = elig1 && (!elig0 || !last_grant);
    w_we    = win1 ? we1    : we0;
    w_addr  = win1 ? addr1  : addr0;
    w_wdata = win1 ? wdata1 : wdata0;
    w_inr   = (w_addr >= BASE_A) && (w_addr <= TOP_A);
`ifdef RW_ARB_LOCK_EN
    w_lock  = win1 ? lock1 : lock0;
`endif
  end

  // Sequencer: IDLE accepts, ACCESS drives the RAM, WAIT captures read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur         <= 1'b0;
      cur_we      <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata       <= '0;
      mem_address <= '0;
      mem_WE      <= 1'b0;
      mem_data_in <= '0;
`ifdef RW_ARB_LOCK_EN
      lock_act    <= 1'b0;
      lock_own    <= 1'b0;
      cur_lock    <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            last_grant <= win1;
            if (w_inr) begin
              mem_address <= w_addr;
              mem_data_in <= w_wdata;
              mem_WE      <= w_we;
              cur         <= win1;
              cur_we      <= w_we;
`ifdef RW_ARB_LOCK_EN
              cur_lock    <= w_lock;
              if (w_lock) begin
                lock_act <= 1'b1;
                lock_own <= win1;
              end
`endif
              state       <= ACCESS;
            end else begin
              // Out of range: error completion without touching the RAM.
              if (win1) begin
                ack1 <= 1'b1;
                err1 <= 1'b1;
              end else begin
                ack0 <= 1'b1;
                err0 <= 1'b1;
              end
              rdata <= '0;
            end
          end
        end
        ACCESS: begin
          mem_WE <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (!cur_we) rdata <= mem_data_out;
          if (cur) ack1 <= 1'b1;
          else     ack0 <= 1'b1;
`ifdef RW_ARB_LOCK_EN
          // Only the owner runs while locked, so an unlocked completion ends it.
          if (!cur_lock) lock_act <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
